apb_cmd_master: RTL and testbench

- Converts a simple valid/ready command stream into APB3 transfers.
- Drives the `PSELx`/`PENABLE`/`PWRITE`/`PADDR`/`PWDATA` bus directly into `apb_uart_top`.
- Returns read data and error status on a valid/ready response channel.
- Sits upstream of the UART slave and replaces the testbench VIP as bus master in system builds; adds a per-transfer `PREADY` timeout.

---
 rtl/apb_master_pkg.sv | 27 ++
 rtl/apb_wait_timer.sv | 35 +++
 rtl/apb_cmd_master.sv | 115 +++++++++++
 tb/tb_apb_cmd_master.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master.
// State encoding, response bundle and width defaults.
package apb_master_pkg;

  localparam int APB_DW = 32;
  localparam int APB_AW = 32;
  localparam int APB_TO = 16;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_e;

  typedef struct packed {
    logic [APB_DW-1:0] rdata;
    logic              slverr;
    logic              timeout;
  } apb_rsp_t;

  // Counter width able to hold n; never below 1 bit.
  function automatic int tmr_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Saturating wait counter with a programmable limit.
// clk/rst, clear, enable, limit in; expired out.
module apb_wait_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH:0]   nxt;

  assign nxt = {1'b0, cnt} + (WIDTH+1)'(1);

  // Fires during the enabled cycle that makes
  // the count reach the limit; limit 0 never fires.
  assign expired = enable
                && (limit != '0)
                && (nxt >= {1'b0, limit});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != '1)) begin
      cnt <= cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/apb_cmd_master.sv
// Valid/ready command stream to APB3 master bridge.
// cmd_* in, rsp_* out, APB P* bus to the slave.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int DATA_WIDTH     = APB_DW,
  parameter int ADDR_WIDTH     = APB_AW,
  parameter int TIMEOUT_CYCLES = APB_TO
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSELx,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int TW = tmr_width(TIMEOUT_CYCLES);

  apb_mst_state_e state;
  logic           accept;
  logic           expired;

  assign accept = (state == IDLE)
               && cmd_valid && cmd_ready;

  apb_wait_timer #(
    .WIDTH (TW)
  ) u_timer (
    .clk     (PCLK),
    .rst     (PRESET),
    .clear   (accept),
    .enable  ((state == ACCESS) && !PREADY),
    .limit   (TW'(TIMEOUT_CYCLES)),
    .expired (expired)
  );

  // PADDR/PWRITE/PWDATA double as the latched
  // command and hold their value while idle.
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_slverr  <= 1'b0;
      rsp_timeout <= 1'b0;
      PSELx       <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            PWRITE    <= cmd_write;
            PADDR     <= cmd_addr;
            PWDATA    <= cmd_wdata;
            PSELx     <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          PENABLE <= 1'b1;
          state   <= ACCESS;
        end
        ACCESS: begin
          if (PREADY) begin
            rsp_rdata   <= PWRITE ? '0 : PRDATA;
            rsp_slverr  <= PSLVERR;
            rsp_timeout <= 1'b0;
            rsp_valid   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end else if (expired) begin
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b1;
            rsp_timeout <= 1'b1;
            rsp_valid   <= 1'b1;
            PSELx       <= 1'b0;
            PENABLE     <= 1'b0;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed self-checking bench for apb_cmd_master.
// Samples on the falling edge, drives after it.
module tb_apb_cmd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr, rsp_timeout;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata, prdata;
  logic        pready, pslverr;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  apb_cmd_master dut (
    .PCLK        (clk),
    .PRESET      (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_slverr  (rsp_slverr),
    .rsp_timeout (rsp_timeout),
    .PSELx       (psel),
    .PENABLE     (penable),
    .PWRITE      (pwrite),
    .PADDR       (paddr),
    .PWDATA      (pwdata),
    .PRDATA      (prdata),
    .PREADY      (pready),
    .PSLVERR     (pslverr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a falling edge with cmd_ready high;
  // returns at the falling edge of cycle N+1.
  task automatic send(input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("hs_rsp_valid", rsp_valid, 0);
    chk("hs_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 0; cmd_write = 0;
    cmd_addr = 0; cmd_wdata = 0;
    rsp_ready = 0; prdata = 0;
    pready = 0; pslverr = 0;

    // reset state
    repeat (3) tick();
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_slverr", rsp_slverr, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    rst = 1'b0;
    tick();
    chk("rel_cmd_ready", cmd_ready, 1);

    // write, zero wait; PRDATA must not leak
    pready = 1'b1;
    prdata = 32'hDEAD_BEEF;
    send(1'b1, 32'h0, 32'h83);
    chk("w_setup_psel", psel, 1);
    chk("w_setup_pen", penable, 0);
    chk("w_setup_pwrite", pwrite, 1);
    chk("w_setup_paddr", paddr, 32'h0);
    chk("w_setup_pwdata", pwdata, 32'h83);
    chk("w_setup_cmd_ready", cmd_ready, 0);
    tick();
    chk("w_acc_psel", psel, 1);
    chk("w_acc_pen", penable, 1);
    chk("w_acc_rsp_valid", rsp_valid, 0);
    tick();
    chk("w_rsp_valid", rsp_valid, 1);
    chk("w_rsp_slverr", rsp_slverr, 0);
    chk("w_rsp_timeout", rsp_timeout, 0);
    chk("w_rsp_rdata", rsp_rdata, 0);
    chk("w_rsp_psel", psel, 0);
    chk("w_rsp_pen", penable, 0);
    handshake();
    chk("w_idle_paddr", paddr, 32'h0);
    chk("w_idle_pwdata", pwdata, 32'h83);
    chk("w_idle_pwrite", pwrite, 1);

    // read 0x14, three wait cycles
    pready = 1'b0;
    prdata = 32'h99;
    send(1'b0, 32'h14, 32'h0);
    chk("r_setup_paddr", paddr, 32'h14);
    chk("r_setup_pwrite", pwrite, 0);
    for (int i = 2; i <= 5; i++) begin
      tick();
      chk("r_acc_pen", penable, 1);
      chk("r_acc_psel", psel, 1);
      chk("r_acc_paddr", paddr, 32'h14);
      chk("r_acc_rsp_valid", rsp_valid, 0);
    end
    pready = 1'b1;
    prdata = 32'h60;
    tick();
    pready = 1'b0;
    prdata = 32'h0;
    chk("r_rsp_valid", rsp_valid, 1);
    chk("r_rsp_rdata", rsp_rdata, 32'h60);
    chk("r_rsp_slverr", rsp_slverr, 0);

    // backpressure: hold the read response
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_rsp_valid", rsp_valid, 1);
      chk("bp_rsp_rdata", rsp_rdata, 32'h60);
      chk("bp_cmd_ready", cmd_ready, 0);
      chk("bp_psel", psel, 0);
    end
    handshake();

    // PSLVERR while waiting is ignored
    send(1'b0, 32'h1C, 32'h0);
    tick();
    pready = 1'b0;
    pslverr = 1'b1;
    tick();
    chk("e0_wait_rsp_valid", rsp_valid, 0);
    pready = 1'b1;
    pslverr = 1'b0;
    prdata = 32'h11;
    tick();
    chk("e0_rsp_valid", rsp_valid, 1);
    chk("e0_rsp_slverr", rsp_slverr, 0);
    chk("e0_rsp_rdata", rsp_rdata, 32'h11);
    handshake();

    // slave error, zero wait
    pslverr = 1'b1;
    prdata = 32'h5A;
    send(1'b0, 32'h1C, 32'h0);
    tick();
    tick();
    pslverr = 1'b0;
    chk("e1_rsp_valid", rsp_valid, 1);
    chk("e1_rsp_slverr", rsp_slverr, 1);
    chk("e1_rsp_timeout", rsp_timeout, 0);
    chk("e1_rsp_rdata", rsp_rdata, 32'h5A);
    handshake();

    // timeout after 16 waiting ACCESS cycles
    pready = 1'b0;
    prdata = 32'hFF;
    send(1'b0, 32'h8, 32'h0);
    for (int c = 2; c <= 17; c++) begin
      tick();
      chk("to_wait_rsp_valid", rsp_valid, 0);
      chk("to_wait_psel", psel, 1);
    end
    tick();
    chk("to_rsp_valid", rsp_valid, 1);
    chk("to_rsp_timeout", rsp_timeout, 1);
    chk("to_rsp_slverr", rsp_slverr, 1);
    chk("to_rsp_rdata", rsp_rdata, 0);
    chk("to_psel", psel, 0);
    handshake();

    // reset during ACCESS
    send(1'b1, 32'h4, 32'h77);
    tick();
    chk("rm_acc_pen", penable, 1);
    #2 rst = 1'b1;
    #1;
    chk("rm_psel_drop", psel, 0);
    chk("rm_pen_drop", penable, 0);
    chk("rm_cmd_ready", cmd_ready, 0);
    tick();
    tick();
    rst = 1'b0;
    pready = 1'b1;
    tick();
    chk("rm_rel_cmd_ready", cmd_ready, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rm_no_rsp", rsp_valid, 0);
      chk("rm_no_psel", psel, 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
